jump_stall_ctrl: RTL and testbench



---
 rtl/jump_stall_pkg.sv | 18 +
 rtl/sat_counter.sv | 28 ++
 rtl/jump_stall_ctrl.sv | 166 ++++++++++++++++
 tb/tb_jump_stall_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_stall_pkg.sv
// Shared definitions for the jump-stall controller: FSM state encoding and
// parameter defaults used by jump_stall_ctrl and its counters.
package jump_stall_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_WB = 2'd1,
        FLUSH   = 2'd2
    } stall_state_e;

    localparam int DEFAULT_FLUSH_NOPS = 1;
    localparam int DEFAULT_CNT_W      = 16;
    localparam int DEFAULT_WDT_LIMIT  = 64;

    // Width of the flush bubble down-counter (FLUSH_NOPS tops out at 15).
    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear, increments on i_inc and holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_value
);

    logic [CNT_W-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = (r_value == {CNT_W{1'b1}});

    // Clear wins over increment; increment stops once the value is all-ones.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_value <= '0;
        end else if (i_inc && !w_at_max) begin
            r_value <= r_value + CNT_W'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/jump_stall_ctrl.sv
// ID-stage jump-stall controller. Raises stall on a decoded jump-class
// instruction, holds it until WB commits (wb_reset), then forces FLUSH_NOPS
// bubble cycles so stale IFID contents are discarded.
// Optional watchdog: define JUMP_STALL_WDT_EN to force a release after
// WDT_LIMIT cycles in WAIT_WB (sets sticky wdt_err). Port list is identical
// in both builds.
module jump_stall_ctrl
    import jump_stall_pkg::*;
#(
    parameter int FLUSH_NOPS = DEFAULT_FLUSH_NOPS,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int WDT_LIMIT  = DEFAULT_WDT_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic             inst_is_jump,
    input  logic             wb_reset,
    output logic             stall,
    output logic             bubble,
    output logic             busy,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             spurious_reset,
    output logic             wdt_err
);

    // Elaboration-time parameter checks.
    if (FLUSH_NOPS < 1 || FLUSH_NOPS > 15) begin : g_bad_flush_nops
        $error("jump_stall_ctrl: FLUSH_NOPS must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("jump_stall_ctrl: CNT_W must be at least 1");
    end
    if (WDT_LIMIT < 1) begin : g_bad_wdt_limit
        $error("jump_stall_ctrl: WDT_LIMIT must be at least 1");
    end

    stall_state_e           r_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic                   r_stall;
    logic                   r_bubble;
    logic                   r_busy;
    logic                   r_spurious;
    logic                   r_wdt_err;

    logic w_jump;
    logic w_enter;
    logic w_timeout;
    logic w_release;
    logic w_in_wait;
    logic w_clear;

    assign w_jump    = inst_valid & inst_is_jump;
    assign w_enter   = (r_state == RUN) & w_jump;
    assign w_in_wait = (r_state == WAIT_WB);
    assign w_release = w_in_wait & (wb_reset | w_timeout);
    assign w_clear   = ~rst_n;

`ifdef JUMP_STALL_WDT_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);

    logic [WDT_W-1:0] r_wdt;

    // Timeout fires on the WDT_LIMIT-th cycle spent waiting for WB.
    assign w_timeout = w_in_wait & (r_wdt == WDT_W'(WDT_LIMIT - 1));

    // Watchdog: cleared on entry to WAIT_WB, counts every cycle spent there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdt <= '0;
        end else if (w_enter) begin
            r_wdt <= '0;
        end else if (w_in_wait && !w_timeout) begin
            r_wdt <= r_wdt + WDT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Main control FSM; all handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_stall     <= 1'b0;
            r_bubble    <= 1'b0;
            r_busy      <= 1'b0;
            r_spurious  <= 1'b0;
            r_wdt_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    // A release request with nothing to release is flagged,
                    // even when a jump arrives on the same edge.
                    if (wb_reset) begin
                        r_spurious <= 1'b1;
                    end
                    if (w_jump) begin
                        r_state <= WAIT_WB;
                        r_stall <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_WB: begin
                    // Instruction inputs are ignored: IFID is sending NOPs.
                    if (wb_reset || w_timeout) begin
                        r_state     <= FLUSH;
                        r_stall     <= 1'b0;
                        r_bubble    <= 1'b1;
                        r_flush_cnt <= FLUSH_CNT_W'(FLUSH_NOPS - 1);
                        // A genuine WB release on the timeout cycle is normal.
                        if (!wb_reset) begin
                            r_wdt_err <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Jumps and wb_reset are ignored while bubbles drain.
                    if (r_flush_cnt == '0) begin
                        r_state  <= RUN;
                        r_bubble <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_flush_cnt <= '0;
                    r_stall     <= 1'b0;
                    r_bubble    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Number of stalls entered.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_jump_cnt (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_enter),
        .o_value (jump_cnt)
    );

    // Cycles with stall high: one per edge taken while in WAIT_WB.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cycles (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_in_wait),
        .o_value (stall_cycles)
    );

    assign stall          = r_stall;
    assign bubble         = r_bubble;
    assign busy           = r_busy;
    assign spurious_reset = r_spurious;
    assign wdt_err        = r_wdt_err;

endmodule

// File: tb/tb_jump_stall_ctrl.sv
// Bench for jump_stall_ctrl: two instances (FLUSH_NOPS=1/CNT_W=16 and
// FLUSH_NOPS=3/CNT_W=4, both WDT_LIMIT=8) share one input stream and are
// compared every cycle against a behavioural model, plus directed scenarios
// with literal expectations.
module tb_jump_stall_ctrl;

    localparam int WDT_LIMIT = 8;
`ifdef JUMP_STALL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    // ---------------- clock / reset / inputs ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic inst_valid;
    logic inst_is_jump;
    logic wb_reset;

    always #5 clk = ~clk;

    // ---------------- DUT A: FLUSH_NOPS=1, CNT_W=16 ----------------
    logic        a_stall, a_bubble, a_busy, a_spur, a_wdt;
    logic [15:0] a_jc, a_sc;

    jump_stall_ctrl #(
        .FLUSH_NOPS (1),
        .CNT_W      (16),
        .WDT_LIMIT  (WDT_LIMIT)
    ) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_valid     (inst_valid),
        .inst_is_jump   (inst_is_jump),
        .wb_reset       (wb_reset),
        .stall          (a_stall),
        .bubble         (a_bubble),
        .busy           (a_busy),
        .jump_cnt       (a_jc),
        .stall_cycles   (a_sc),
        .spurious_reset (a_spur),
        .wdt_err        (a_wdt)
    );

    // ---------------- DUT B: FLUSH_NOPS=3, CNT_W=4 ----------------
    logic       b_stall, b_bubble, b_busy, b_spur, b_wdt;
    logic [3:0] b_jc, b_sc;

    jump_stall_ctrl #(
        .FLUSH_NOPS (3),
        .CNT_W      (4),
        .WDT_LIMIT  (WDT_LIMIT)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_valid     (inst_valid),
        .inst_is_jump   (inst_is_jump),
        .wb_reset       (wb_reset),
        .stall          (b_stall),
        .bubble         (b_bubble),
        .busy           (b_busy),
        .jump_cnt       (b_jc),
        .stall_cycles   (b_sc),
        .spurious_reset (b_spur),
        .wdt_err        (b_wdt)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: are we stalled, how long, how many bubbles still owed.
    int fnops [2] = '{1, 3};
    int cmax  [2] = '{65535, 15};
    bit m_in_stall [2];
    int m_age      [2];
    int m_bub_left [2];
    int m_jc       [2];
    int m_sc       [2];
    bit m_spur     [2];
    bit m_wdt      [2];

    function automatic int sat_inc(input int x, input int mx);
        return (x >= mx) ? mx : x + 1;
    endfunction

    task automatic model_step(input bit v, input bit j, input bit w, input bit r);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_in_stall[k] = 1'b0;
                m_age[k]      = 0;
                m_bub_left[k] = 0;
                m_jc[k]       = 0;
                m_sc[k]       = 0;
                m_spur[k]     = 1'b0;
                m_wdt[k]      = 1'b0;
            end else if (m_in_stall[k]) begin
                m_sc[k]  = sat_inc(m_sc[k], cmax[k]);
                m_age[k] = m_age[k] + 1;
                if (w || (WDT_ON && m_age[k] >= WDT_LIMIT)) begin
                    m_in_stall[k] = 1'b0;
                    m_bub_left[k] = fnops[k];
                    if (!w) m_wdt[k] = 1'b1;
                end
            end else if (m_bub_left[k] > 0) begin
                m_bub_left[k] = m_bub_left[k] - 1;
            end else begin
                if (w) m_spur[k] = 1'b1;
                if (v && j) begin
                    m_in_stall[k] = 1'b1;
                    m_age[k]      = 0;
                    m_jc[k]       = sat_inc(m_jc[k], cmax[k]);
                end
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    task automatic compare_all();
        chk("a.stall",          int'(a_stall),  int'(m_in_stall[0]));
        chk("a.bubble",         int'(a_bubble), int'(m_bub_left[0] > 0));
        chk("a.busy",           int'(a_busy),   int'(m_in_stall[0] || m_bub_left[0] > 0));
        chk("a.jump_cnt",       int'(a_jc),     m_jc[0]);
        chk("a.stall_cycles",   int'(a_sc),     m_sc[0]);
        chk("a.spurious_reset", int'(a_spur),   int'(m_spur[0]));
        chk("a.wdt_err",        int'(a_wdt),    int'(m_wdt[0]));
        chk("b.stall",          int'(b_stall),  int'(m_in_stall[1]));
        chk("b.bubble",         int'(b_bubble), int'(m_bub_left[1] > 0));
        chk("b.busy",           int'(b_busy),   int'(m_in_stall[1] || m_bub_left[1] > 0));
        chk("b.jump_cnt",       int'(b_jc),     m_jc[1]);
        chk("b.stall_cycles",   int'(b_sc),     m_sc[1]);
        chk("b.spurious_reset", int'(b_spur),   int'(m_spur[1]));
        chk("b.wdt_err",        int'(b_wdt),    int'(m_wdt[1]));
    endtask

    // ---------------- driver ----------------
    // Apply inputs for one cycle, advance the model at the edge, compare at
    // the falling edge.
    task automatic step(input bit v, input bit j, input bit w, input bit r);
        inst_valid   = v;
        inst_is_jump = j;
        wb_reset     = w;
        rst_n        = ~r;
        @(posedge clk);
        model_step(v, j, w, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bub_a;
        int bub_b;
        int stall_seen;

        inst_valid   = 1'b0;
        inst_is_jump = 1'b0;
        wb_reset     = 1'b0;
        rst_n        = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        chk("reset a.stall",   int'(a_stall), 0);
        chk("reset b.bubble",  int'(b_bubble), 0);
        chk("reset a.jump_cnt", int'(a_jc), 0);

        // Single jump: 5 stall cycles, then bubbles (1 on A, 3 on B)
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("jump a.stall", int'(a_stall), 1);
        chk("jump a.busy",  int'(a_busy), 1);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("single a.stall_cycles", int'(a_sc), 5);
        chk("single b.stall_cycles", int'(b_sc), 5);
        chk("single a.jump_cnt",     int'(a_jc), 1);
        chk("release a.stall",       int'(a_stall), 0);
        bub_a = int'(a_bubble);
        bub_b = int'(b_bubble);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            bub_a += int'(a_bubble);
            bub_b += int'(b_bubble);
        end
        chk("single a.bubble_len", bub_a, 1);
        chk("single b.bubble_len", bub_b, 3);

        // Back-to-back jumps: jump held high through the flush
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        bub_b = int'(b_bubble);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            bub_b += int'(b_bubble);
        end
        chk("b2b b.bubble_len", bub_b, 3);
        chk("b2b b.stall",      int'(b_stall), 1);
        chk("b2b b.jump_cnt",   int'(b_jc), 2);
        chk("b2b a.jump_cnt",   int'(a_jc), 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Spurious: wb_reset in FLUSH does not flag, wb_reset in RUN does
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush wb b.spurious", int'(b_spur), 0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run wb b.spurious", int'(b_spur), 1);
        chk("run wb a.spurious", int'(a_spur), 1);
        idle(5);
        chk("sticky a.spurious", int'(a_spur), 1);

        // Jump and wb_reset on the same RUN edge: jump wins, flag still set
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("jump+wb a.stall",    int'(a_stall), 1);
        chk("jump+wb a.spurious", int'(a_spur), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Reset mid-WAIT_WB, then a normal stall
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        do_reset();
        chk("midreset a.stall",        int'(a_stall), 0);
        chk("midreset a.busy",         int'(a_busy), 0);
        chk("midreset a.stall_cycles", int'(a_sc), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("after reset a.stall",    int'(a_stall), 1);
        chk("after reset a.jump_cnt", int'(a_jc), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Saturation: 3 stalls of 8 cycles; wb_reset lands on the watchdog
        // limit cycle, which must count as a normal release
        do_reset();
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            idle(7);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            idle(4);
        end
        chk("sat b.stall_cycles", int'(b_sc), 15);
        chk("sat a.stall_cycles", int'(a_sc), 24);
        chk("limit wb a.wdt_err", int'(a_wdt), 0);

        // Watchdog: wb_reset never driven for 100 cycles
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        stall_seen = int'(a_stall);
        for (int i = 0; i < 100; i++) begin
            idle(1);
            stall_seen += int'(a_stall);
        end
        chk("wdt a.stall_len", stall_seen, WDT_ON ? WDT_LIMIT : 101);
        chk("wdt a.wdt_err",   int'(a_wdt), WDT_ON ? 1 : 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
